// File: rtl/trace_record_decoder_if.sv
// Byte-stream input and decoded-record output bundle for trace_record_decoder.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1; the sender keeps valid and its payload stable until that edge.
// The decoder connects through the slave modport, its environment through master.
interface trace_record_decoder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_cycle;
  logic [31:0] rec_pc;
  logic [31:0] rec_instr;
  logic [4:0]  rec_rd;
  logic        rec_reg_write;
  logic [31:0] rec_data;
  logic        err_checksum;
  logic        err_type;
  logic        err_timeout;
  logic [15:0] err_count;
  logic [31:0] rec_count;
  logic [1:0]  dbg_state;

  modport slave (
    input  in_valid, in_data, rec_ready,
    output in_ready, rec_valid, rec_cycle, rec_pc, rec_instr, rec_rd,
           rec_reg_write, rec_data, err_checksum, err_type, err_timeout,
           err_count, rec_count, dbg_state
  );

  modport master (
    output in_valid, in_data, rec_ready,
    input  in_ready, rec_valid, rec_cycle, rec_pc, rec_instr, rec_rd,
           rec_reg_write, rec_data, err_checksum, err_type, err_timeout,
           err_count, rec_count, dbg_state
  );
endinterface

// File: rtl/trace_record_decoder.sv
// Consumes the per-retirement trace byte stream, resynchronises on SYNC_BYTE,
// validates type and XOR checksum, and presents commit records on a
// valid/ready output. dbg_state exposes the FSM: 0 HUNT, 1 TYPE, 2 PAYLOAD, 3 CHK.
module trace_record_decoder #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  TYPE_COMMIT    = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst,
  trace_record_decoder_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_HUNT, S_TYPE, S_PAYLOAD, S_CHK} state_t;

  state_t       state, state_nxt;
  logic [4:0]   idx;
  logic [7:0]   xor_q;
  logic [135:0] shadow;
  logic [TW-1:0] tmo_cnt;

  logic        rec_valid_q;
  logic [31:0] rec_cycle_q, rec_pc_q, rec_instr_q, rec_data_q, rec_count_q;
  logic [4:0]  rec_rd_q;
  logic        rec_rw_q;
  logic        err_chk_q, err_type_q, err_tmo_q;
  logic [15:0] err_count_q;

  logic in_ready_w, accept, count_en, tmo_hit;
  logic type_ok, type_bad, chk_ok, chk_bad, err_any;
  logic unused_rdbyte_bits;

  // Only the record-completing byte waits for the consumer to free the output.
  assign in_ready_w = !(state == S_CHK && rec_valid_q && !bus.rec_ready);
  assign accept     = bus.in_valid && in_ready_w;
  // The self-imposed CHK stall does not count towards the idle timeout.
  assign count_en   = (state != S_HUNT) && !accept && in_ready_w;
  assign tmo_hit    = count_en && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_any    = type_bad || chk_bad || tmo_hit;
  assign unused_rdbyte_bits = ^shadow[102:101];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HUNT;
    else     state <= state_nxt;
  end

  // Next-state decode; every move except timeout needs an accepted byte.
  always_comb begin
    state_nxt = state;
    type_ok   = 1'b0;
    type_bad  = 1'b0;
    chk_ok    = 1'b0;
    chk_bad   = 1'b0;
    case (state)
      S_HUNT: if (accept && bus.in_data == SYNC_BYTE) state_nxt = S_TYPE;
      S_TYPE: if (accept) begin
        if (bus.in_data == TYPE_COMMIT) begin
          type_ok   = 1'b1;
          state_nxt = S_PAYLOAD;
        end else begin
          type_bad  = 1'b1;
          state_nxt = S_HUNT;
        end
      end
      S_PAYLOAD: if (accept && idx == 5'd16) state_nxt = S_CHK;
      S_CHK: if (accept) begin
        if (bus.in_data == xor_q) chk_ok  = 1'b1;
        else                      chk_bad = 1'b1;
        state_nxt = S_HUNT;
      end
      default: state_nxt = S_HUNT;
    endcase
    if (tmo_hit) state_nxt = S_HUNT;
  end

  // Payload assembly in a shadow register, running XOR, idle timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      xor_q   <= '0;
      shadow  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (type_ok) begin
        idx   <= '0;
        xor_q <= bus.in_data;
      end else if (state == S_PAYLOAD && accept) begin
        idx   <= idx + 5'd1;
        xor_q <= xor_q ^ bus.in_data;
        shadow[{idx, 3'b000} +: 8] <= bus.in_data;
      end
      if (accept || state_nxt == S_HUNT) tmo_cnt <= '0;
      else if (count_en)                 tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Output record, counters and one-cycle error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_valid_q <= 1'b0;
      rec_cycle_q <= '0;
      rec_pc_q    <= '0;
      rec_instr_q <= '0;
      rec_rd_q    <= '0;
      rec_rw_q    <= 1'b0;
      rec_data_q  <= '0;
      rec_count_q <= '0;
      err_chk_q   <= 1'b0;
      err_type_q  <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (chk_ok) begin
        rec_valid_q <= 1'b1;
        rec_cycle_q <= shadow[31:0];
        rec_pc_q    <= shadow[63:32];
        rec_instr_q <= shadow[95:64];
        rec_rd_q    <= shadow[100:96];
        rec_rw_q    <= shadow[103];
        rec_data_q  <= shadow[135:104];
        rec_count_q <= rec_count_q + 32'd1;
      end else if (rec_valid_q && bus.rec_ready) begin
        rec_valid_q <= 1'b0;
      end
      err_chk_q  <= chk_bad;
      err_type_q <= type_bad;
      err_tmo_q  <= tmo_hit;
      if (err_any && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
    end
  end

  assign bus.in_ready      = in_ready_w;
  assign bus.rec_valid     = rec_valid_q;
  assign bus.rec_cycle     = rec_cycle_q;
  assign bus.rec_pc        = rec_pc_q;
  assign bus.rec_instr     = rec_instr_q;
  assign bus.rec_rd        = rec_rd_q;
  assign bus.rec_reg_write = rec_rw_q;
  assign bus.rec_data      = rec_data_q;
  assign bus.err_checksum  = err_chk_q;
  assign bus.err_type      = err_type_q;
  assign bus.err_timeout   = err_tmo_q;
  assign bus.err_count     = err_count_q;
  assign bus.rec_count     = rec_count_q;
  assign bus.dbg_state     = state;
endmodule

// File: tb/tb_trace_record_decoder.sv
// Directed bench for trace_record_decoder: table of records plus hand-written
// sequences for checksum/type errors, timeout, backpressure and mid-frame reset.
module tb_trace_record_decoder;
  localparam int TMO = 32;

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  rdb;
    logic [31:0] data;
    logic [4:0]  exp_rd;
    logic        exp_rw;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_record_decoder_if bus ();

  trace_record_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_chk = 0, n_type = 0, n_tmo = 0, n_vcyc = 0;
  int last_wait = 0;
  int exp_rec = 0, exp_err = 0;
  logic [7:0] fr [20];
  vec_t tbl [4];

  // Pulse and valid-cycle monitor.
  always @(negedge clk) begin
    if (bus.err_checksum) n_chk++;
    if (bus.err_type)     n_type++;
    if (bus.err_timeout)  n_tmo++;
    if (bus.rec_valid)    n_vcyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    logic [7:0] c;
    fr[0] = 8'hA5;
    fr[1] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      fr[2 + i]  = v.cyc[8*i +: 8];
      fr[6 + i]  = v.pc[8*i +: 8];
      fr[10 + i] = v.instr[8*i +: 8];
      fr[15 + i] = v.data[8*i +: 8];
    end
    fr[14] = v.rdb;
    c = 8'h00;
    for (int i = 1; i < 19; i++) c = c ^ fr[i];
    fr[19] = c;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    last_wait = w;
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_byte: in_ready got 0 expected 1 after 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(fr[i]);
  endtask

  task automatic check_rec(input string tag, input vec_t v);
    check({tag, ".cycle"}, bus.rec_cycle, v.cyc);
    check({tag, ".pc"},    bus.rec_pc, v.pc);
    check({tag, ".instr"}, bus.rec_instr, v.instr);
    check({tag, ".rd"},    bus.rec_rd, v.exp_rd);
    check({tag, ".rw"},    bus.rec_reg_write, v.exp_rw);
    check({tag, ".data"},  bus.rec_data, v.data);
  endtask

  // Frame already in fr, rec_ready=1: record appears one cycle after CHK, then clears.
  task automatic run_good(input string tag, input vec_t v);
    send_range(0, 19);
    exp_rec++;
    check({tag, ".valid"}, bus.rec_valid, 1'b1);
    check_rec(tag, v);
    check({tag, ".rec_count"}, bus.rec_count, exp_rec);
    @(posedge clk);
    #1;
    check({tag, ".valid_clr"}, bus.rec_valid, 1'b0);
  endtask

  initial begin
    vec_t lit, va, vb;
    int c0, t0, m0, vc0, at, wsum;

    lit = '{cyc: 32'd5, pc: 32'h10, instr: 32'h00500093, rdb: 8'h81, data: 32'd5,
            exp_rd: 5'd1, exp_rw: 1'b1};
    tbl[0] = '{cyc: 32'h0, pc: 32'h0, instr: 32'h0, rdb: 8'h00, data: 32'h0,
               exp_rd: 5'd0, exp_rw: 1'b0};
    tbl[1] = '{cyc: 32'hFFFFFFFF, pc: 32'h80000000, instr: 32'hDEADBEEF, rdb: 8'h7F,
               data: 32'h12345678, exp_rd: 5'd31, exp_rw: 1'b0};
    tbl[2] = '{cyc: 32'h00000100, pc: 32'h00001004, instr: 32'h00A00113, rdb: 8'hE2,
               data: 32'hCAFEF00D, exp_rd: 5'd2, exp_rw: 1'b1};
    tbl[3] = '{cyc: 32'h0A0B0C0D, pc: 32'h00000200, instr: 32'h00000013, rdb: 8'h9F,
               data: 32'hA5A5A5A5, exp_rd: 5'd31, exp_rw: 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.rec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", bus.in_ready, 1'b1);
    check("rst.rec_valid", bus.rec_valid, 1'b0);
    check("rst.rec_count", bus.rec_count, 0);
    check("rst.err_count", bus.err_count, 0);
    check("rst.state", bus.dbg_state, 2'd0);
    check("rst.rec_pc", bus.rec_pc, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Literal frame from the reference trace.
    fr = '{8'hA5, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h50, 8'h00, 8'h81, 8'h05, 8'h00, 8'h00, 8'h00, 8'h53};
    run_good("lit", lit);

    // Table-driven records.
    for (int i = 0; i < 4; i++) begin
      build(tbl[i]);
      run_good($sformatf("tbl%0d", i), tbl[i]);
    end

    // Bad checksum: no record, single pulse, then a good frame.
    c0 = n_chk; vc0 = n_vcyc;
    build(lit);
    fr[19] = 8'h52;
    send_range(0, 19);
    exp_err++;
    repeat (2) @(posedge clk);
    #1;
    check("chk.pulses", n_chk - c0, 1);
    check("chk.no_valid", n_vcyc - vc0, 0);
    check("chk.err_count", bus.err_count, exp_err);
    check("chk.state", bus.dbg_state, 2'd0);
    check("chk.rec_count", bus.rec_count, exp_rec);
    build(lit);
    run_good("after_chk", lit);

    // Garbage before a frame is silently dropped.
    c0 = n_chk; t0 = n_type; m0 = n_tmo;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    build(tbl[2]);
    run_good("garbage", tbl[2]);
    check("garbage.no_err", (n_chk - c0) + (n_type - t0) + (n_tmo - m0), 0);
    check("garbage.err_count", bus.err_count, exp_err);

    // Unknown type, and SYNC in the type slot.
    t0 = n_type;
    send_byte(8'hA5); send_byte(8'h02);
    exp_err++;
    @(posedge clk);
    #1;
    check("type.pulses", n_type - t0, 1);
    check("type.err_count", bus.err_count, exp_err);
    t0 = n_type;
    send_byte(8'hA5); send_byte(8'hA5);
    exp_err++;
    @(posedge clk);
    #1;
    check("type_sync.pulses", n_type - t0, 1);
    check("type_sync.state", bus.dbg_state, 2'd0);

    // Timeout after SYNC: pulse seen in idle cycle TMO+1 counted from the SYNC edge.
    m0 = n_tmo; at = 0;
    send_byte(8'hA5);
    for (int c = 1; c <= TMO + 5; c++) begin
      @(negedge clk);
      if (bus.err_timeout && at == 0) at = c;
    end
    exp_err++;
    check("tmo.at_cycle", at, TMO + 1);
    check("tmo.pulses", n_tmo - m0, 1);
    check("tmo.err_count", bus.err_count, exp_err);
    check("tmo.state", bus.dbg_state, 2'd0);

    // Idle gap of TMO-1 cycles mid-payload is tolerated.
    m0 = n_tmo;
    @(posedge clk);
    #1;
    build(tbl[1]);
    send_range(0, 5);
    repeat (TMO - 1) @(posedge clk);
    #1;
    send_range(6, 18);
    send_byte(fr[19]);
    exp_rec++;
    check("gap.valid", bus.rec_valid, 1'b1);
    check_rec("gap", tbl[1]);
    check("gap.no_tmo", n_tmo - m0, 0);
    @(posedge clk);
    #1;

    // Backpressure: first record held, only second CHK byte stalls.
    bus.rec_ready = 1'b0;
    m0 = n_tmo;
    va = tbl[2]; vb = tbl[3];
    build(va);
    send_range(0, 19);
    exp_rec++;
    check("bp1.valid", bus.rec_valid, 1'b1);
    build(vb);
    wsum = 0;
    for (int i = 0; i < 19; i++) begin
      send_byte(fr[i]);
      wsum += last_wait;
    end
    check("bp.payload_no_stall", wsum, 0);
    check_rec("bp1_held", va);
    bus.in_valid = 1'b1;
    bus.in_data  = fr[19];
    wsum = 0;
    for (int c = 0; c < TMO + 8; c++) begin
      @(negedge clk);
      if (bus.in_ready) wsum++;
    end
    check("bp.chk_stalled", wsum, 0);
    check("bp.state_chk", bus.dbg_state, 2'd3);
    check("bp.no_tmo", n_tmo - m0, 0);
    check_rec("bp1_stable", va);
    @(posedge clk);
    #1;
    bus.rec_ready = 1'b1;
    @(negedge clk);
    check("bp.ready_up", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_rec++;
    check("bp2.valid_no_gap", bus.rec_valid, 1'b1);
    check_rec("bp2", vb);
    check("bp2.rec_count", bus.rec_count, exp_rec);
    @(posedge clk);
    #1;
    check("bp2.valid_clr", bus.rec_valid, 1'b0);

    // Reset mid-frame.
    build(lit);
    send_range(0, 9);
    rst = 1'b1;
    #1;
    check("mrst.rec_valid", bus.rec_valid, 1'b0);
    check("mrst.fields", {bus.rec_cycle, bus.rec_pc} | {bus.rec_instr, bus.rec_data}, 0);
    check("mrst.rd_rw", {bus.rec_rd, bus.rec_reg_write}, 0);
    check("mrst.counts", {bus.rec_count, bus.err_count}, 0);
    check("mrst.pulses", {bus.err_checksum, bus.err_type, bus.err_timeout}, 0);
    check("mrst.in_ready", bus.in_ready, 1'b1);
    check("mrst.state", bus.dbg_state, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rec = 0; exp_err = 0;
    c0 = n_chk; t0 = n_type; m0 = n_tmo; vc0 = n_vcyc;
    send_range(10, 19);
    @(posedge clk);
    #1;
    check("mrst.tail_no_err", (n_chk - c0) + (n_type - t0) + (n_tmo - m0), 0);
    check("mrst.tail_no_rec", n_vcyc - vc0, 0);
    check("mrst.tail_state", bus.dbg_state, 2'd0);
    run_good("mrst.next", lit);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
